display_sched: RTL and testbench
================================

# display_sched

Display scheduler between the RV_CPU register write-back stream and the SevenSegDisplay driver. It queues register write-back events and shows each written value as eight hex digits for a guaranteed minimum hold time, so the display stays readable while the CPU runs at full clock rate. It also blanks leading zeros and raises a sticky overflow flag when events are lost. In the top level it replaces direct wiring of the destination register into the digit array.

## Interface

Parameters:
- HOLD_CYCLES, default 50_000_000: cycles each value is shown when a backlog exists; legal range ≥ 1.
- FIFO_DEPTH, default 4: event queue depth; must be a power of two, ≥ 2.
- BLANK_LZ, default 1: 1 enables leading-zero blanking; 0 never blanks.

Ports:
- clk  input  1: the single clock; all logic is on the rising edge.
- rst  input  1: synchronous, active-high reset.
- wb_valid  input  1: the write-back event is valid this cycle.
- wb_rd  input  5: destination register index.
- wb_data  input  32: write-back value.
- ovf_clr  input  1: clears the sticky overflow flag.
- digit_value  output  8×4 (unpacked [7:0] of [3:0]): hex nibbles to SevenSegDisplay; digit 0 is least significant.
- digit_blank  output  8: 1 means the digit is off.
- overflow  output  1: sticky flag, set when an event was dropped.
- busy  output  1: high when the FSM is in HOLD or the FIFO is not empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation

- Push rule: an event is pushed into the FIFO when wb_valid=1 and wb_rd≠0. Writes to x0 are silently ignored and do not set overflow.
- Full FIFO:
  - A push into a full FIFO with no pop in the same cycle drops the incoming event and sets overflow.
  - If a pop happens in the same cycle, the push is accepted and occupancy stays at full.
- FSM states are IDLE and HOLD.
- IDLE:
  - If the FIFO is not empty: pop, load the digits from the popped data, set hold_cnt=HOLD_CYCLES-1, go to HOLD.
  - Otherwise stay in IDLE and keep the current digits.
- HOLD:
  - If hold_cnt≠0: decrement hold_cnt.
  - If hold_cnt=0 and the FIFO is not empty: pop, load, reload hold_cnt, stay in HOLD.
  - If hold_cnt=0 and the FIFO is empty: go to IDLE; the digits keep their last value indefinitely.
- Load: digit_value[i] = data[4i+3:4i].
- Blanking:
  - digit_blank[i]=1 exactly when BLANK_LZ=1 and data[31:4i]==0, for i≥1.
  - digit_blank[0] is always 0, so the value 0 displays as a single "0".
- overflow: set has priority over ovf_clr when both occur in the same cycle.
- Reset:
  - The FSM goes to IDLE, the FIFO is emptied, hold_cnt=0, overflow=0.
  - digit_value is all 4'hF and digit_blank is 8'hFF (display dark).
  - Reset during HOLD discards the queued events and the displayed value.

## Timing

- Latency from wb_valid (sampled at edge t) into an empty FIFO with the FSM in IDLE:
  - The FIFO is written at edge t.
  - The pop and load happen at edge t+1.
  - digit_value and digit_blank are valid after edge t+1, i.e. visible in cycle t+2.
- With a backlog, each value is displayed for exactly HOLD_CYCLES cycles, and the next load follows back-to-back with no IDLE gap.
- fifo_count and busy are registered and reflect the state after each edge.
- Every output is registered; there is no combinational path from any input to any output.

## Structure

- Package display_sched_pkg contains:
  - typedef state_t enum {IDLE, HOLD}
  - typedef nibble_t logic [3:0]
  - function lz_blank(logic [31:0]) returning logic [7:0]
  - localparam reset constants RST_DIGIT=4'hF and RST_BLANK=8'hFF
- Sub-module wb_fifo:
  - Synchronous FIFO, DEPTH×32 bits.
  - Interface: push, pop, data in/out, full, empty, count.
  - Pop-when-empty and push-when-full are ignored inside the sub-module.
- display_sched owns the filter, the overflow logic, the FSM, hold_cnt and the digit registers.

## Test plan

- Reset: assert rst for 2 cycles → digit_value all 4'hF, digit_blank 8'hFF, overflow=0, busy=0, fifo_count=0.
- Single write, HOLD_CYCLES=4: wb_valid at edge t with rd=5, data=32'h0001_2345 → in cycle t+2, digits = 0,0,0,1,2,3,4,5 (digit 7 down to digit 0) and digit_blank=8'hE0. busy drops after the hold expires and the display still shows 12345.
- x0 filter: wb_valid with rd=0, data=32'hDEAD_BEEF → no change to fifo_count, the digits or overflow.
- Back-to-back events, HOLD_CYCLES=4: three writes (0x11, 0x22, 0x33) on consecutive cycles → each value is shown for exactly 4 cycles in order, then the FSM returns to IDLE with 0x33 displayed.
- Overflow, FIFO_DEPTH=4, HOLD_CYCLES=100: six consecutive writes → 1 is displayed, 4 are queued, the 6th is dropped, overflow=1. ovf_clr asserted in the same cycle as a dropped push keeps overflow=1; ovf_clr alone clears it.
- Zero and reset mid-HOLD: write data=0 → digits all 0 and digit_blank=8'hFE. Assert rst during HOLD with 2 events queued → next cycle shows reset values, and no queued value appears afterwards.

Source files
------------

// File: rtl/display_sched_pkg.sv
// Shared types, reset constants and the leading-zero blanking helper
// for the register write-back display scheduler.
package display_sched_pkg;

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   typedef logic [3:0] nibble_t;

   localparam nibble_t    RST_DIGIT = 4'hF;
   localparam logic [7:0] RST_BLANK = 8'hFF;

   // Digit i (i >= 1) is blanked when every nibble from i upwards is zero;
   // digit 0 always lights so a zero value still shows a single "0".
   function automatic logic [7:0] lz_blank(input logic [31:0] data);
      logic [7:0] blank;
      blank = 8'h00;
      for (int i = 1; i < 8; i++) begin
         blank[i] = ((data >> (4 * i)) == 32'h0000_0000);
      end
      return blank;
   endfunction

endpackage

// File: rtl/display_sched_wb_fifo.sv
// Synchronous first-word-fall-through FIFO holding queued write-back values.
// Push into a full FIFO is only taken when a pop frees a slot in the same cycle.
module wb_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [31:0]              din,
   output logic [31:0]              dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [31:0]   mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          wr_en_s;
   logic          rd_en_s;

   assign full    = (count_r == FULL_CNT);
   assign empty   = (count_r == '0);
   assign count   = count_r;
   assign dout    = mem_r[rd_ptr_r];
   assign rd_en_s = pop && !empty;
   assign wr_en_s = push && (!full || rd_en_s);

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({wr_en_s, rd_en_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

endmodule

// File: rtl/display_sched.sv
// Queues CPU register write-back values and shows each on the eight-digit
// display for a minimum hold time, with leading-zero blanking and overflow flag.
module display_sched
   import display_sched_pkg::*;
#(
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int FIFO_DEPTH  = 4,
   parameter int BLANK_LZ    = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wb_valid,
   input  logic [4:0]                    wb_rd,
   input  logic [31:0]                   wb_data,
   input  logic                          ovf_clr,
   output logic [3:0]                    digit_value [7:0],
   output logic [7:0]                    digit_blank,
   output logic                          overflow,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [31:0] HOLD_LOAD = 32'(HOLD_CYCLES - 1);

   state_t        state_r;
   state_t        state_nxt_s;
   logic [31:0]   hold_cnt_r;
   logic [31:0]   hold_nxt_s;
   logic          push_s;
   logic          load_s;
   logic          full_s;
   logic          empty_s;
   logic [31:0]   fifo_dout_s;
   logic [CW-1:0] count_s;

   assign push_s     = wb_valid && (wb_rd != 5'd0);
   assign busy       = (state_r == HOLD) || (count_s != '0);
   assign fifo_count = count_s;

   wb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (load_s),
      .din   (wb_data),
      .dout  (fifo_dout_s),
      .full  (full_s),
      .empty (empty_s),
      .count (count_s)
   );

   // Next-state logic: a pop always coincides with a digit load.
   always_comb begin
      state_nxt_s = state_r;
      hold_nxt_s  = hold_cnt_r;
      load_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (!empty_s) begin
               load_s      = 1'b1;
               hold_nxt_s  = HOLD_LOAD;
               state_nxt_s = HOLD;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         HOLD: begin
            if (hold_cnt_r != 32'd0) begin
               hold_nxt_s = hold_cnt_r - 32'd1;
            end else if (!empty_s) begin
               load_s     = 1'b1;
               hold_nxt_s = HOLD_LOAD;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            hold_nxt_s  = 32'd0;
         end
      endcase
   end

   // FSM, hold counter, digit registers and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         hold_cnt_r  <= 32'd0;
         overflow    <= 1'b0;
         digit_blank <= RST_BLANK;
         for (int i = 0; i < 8; i++) begin
            digit_value[i] <= RST_DIGIT;
         end
      end else begin
         state_r    <= state_nxt_s;
         hold_cnt_r <= hold_nxt_s;
         if (load_s) begin
            for (int i = 0; i < 8; i++) begin
               digit_value[i] <= fifo_dout_s[4*i +: 4];
            end
            digit_blank <= (BLANK_LZ != 0) ? lz_blank(fifo_dout_s) : 8'h00;
         end
         // A dropped event wins over a simultaneous clear.
         if (push_s && full_s && !load_s) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end else begin
            overflow <= overflow;
         end
      end
   end

endmodule

// File: tb/tb_display_sched.sv
// Scoreboard bench: stimulus queues the expected sequence of displayed values,
// a negedge monitor pops one entry per display change and checks hold lengths.
module tb_display_sched;

   localparam int HOLD  = 4;
   localparam int DEPTH = 4;

   logic        clk      = 1'b0;
   logic        rst      = 1'b1;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_rd    = 5'd0;
   logic [31:0] wb_data  = 32'h0;
   logic        ovf_clr  = 1'b0;
   logic [3:0]  digit_value [7:0];
   logic [7:0]  digit_blank;
   logic        overflow;
   logic        busy;
   logic [2:0]  fifo_count;

   display_sched #(
      .HOLD_CYCLES (HOLD),
      .FIFO_DEPTH  (DEPTH),
      .BLANK_LZ    (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .ovf_clr     (ovf_clr),
      .digit_value (digit_value),
      .digit_blank (digit_blank),
      .overflow    (overflow),
      .busy        (busy),
      .fifo_count  (fifo_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] val;
      logic [7:0]  blank;
      int          len;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic logic [31:0] cur_disp();
      logic [31:0] w;
      for (int i = 0; i < 8; i++) w[4*i +: 4] = digit_value[i];
      return w;
   endfunction

   function automatic exp_t mk(input logic [31:0] v, input logic [7:0] b, input int len);
      exp_t e;
      e.val = v; e.blank = b; e.len = len;
      return e;
   endfunction

   // Monitor: each change of the displayed word/blank pattern consumes one entry.
   logic [31:0] prev_disp  = 'x;
   logic [7:0]  prev_blank = 'x;
   int          run_len    = 0;
   int          chk_len    = 0;

   always @(negedge clk) begin
      logic [31:0] d;
      exp_t        e;
      d = cur_disp();
      if (d !== prev_disp || digit_blank !== prev_blank) begin
         if (chk_len != 0) chk("hold_len", 32'(run_len), 32'(chk_len));
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_display: got %h/%h expected no change", d, digit_blank);
            chk_len = 0;
         end else begin
            e = exp_q.pop_front();
            chk("disp_value", d, e.val);
            chk("disp_blank", 32'(digit_blank), 32'(e.blank));
            chk_len = e.len;
         end
         run_len    = 1;
         prev_disp  = d;
         prev_blank = digit_blank;
      end else begin
         run_len++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wb(input logic [4:0] rd, input logic [31:0] d);
      wb_valid = 1'b1;
      wb_rd    = rd;
      wb_data  = d;
      tick();
      wb_valid = 1'b0;
      wb_rd    = 5'd0;
      wb_data  = 32'h0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   initial begin
      // Reset
      exp_q.push_back(mk(32'hFFFF_FFFF, 8'hFF, 0));
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_digits", cur_disp(), 32'hFFFF_FFFF);

      // Single write: visible one cycle after the pop edge
      exp_q.push_back(mk(32'h0001_2345, 8'hE0, 0));
      wb(5'd5, 32'h0001_2345);
      chk("lat_early", cur_disp(), 32'hFFFF_FFFF);
      tick();
      chk("lat_value", cur_disp(), 32'h0001_2345);
      chk("lat_blank", 32'(digit_blank), 32'h0000_00E0);
      wait_idle(20);
      chk("single_keep", cur_disp(), 32'h0001_2345);
      chk("single_count", 32'(fifo_count), 32'd0);

      // x0 writes are ignored
      wb(5'd0, 32'hDEAD_BEEF);
      tick();
      chk("x0_count", 32'(fifo_count), 32'd0);
      chk("x0_overflow", 32'(overflow), 32'd0);
      chk("x0_busy", 32'(busy), 32'd0);
      chk("x0_digits", cur_disp(), 32'h0001_2345);

      // Back-to-back events
      exp_q.push_back(mk(32'h0000_0011, 8'hFC, HOLD));
      exp_q.push_back(mk(32'h0000_0022, 8'hFC, HOLD));
      exp_q.push_back(mk(32'h0000_0033, 8'hFC, 0));
      wb(5'd1, 32'h11);
      wb(5'd2, 32'h22);
      wb(5'd3, 32'h33);
      wait_idle(40);
      chk("b2b_final", cur_disp(), 32'h0000_0033);

      // Overflow: 1 shown, 2 popped at the 6th write, 3..6 queued, 7 and 8 dropped
      for (int k = 1; k <= 6; k++)
         exp_q.push_back(mk(32'hA000_0000 + 32'(k), 8'h00, (k == 6) ? 0 : HOLD));
      for (int k = 1; k <= 6; k++) wb(5'(k), 32'hA000_0000 + 32'(k));
      chk("ovf_not_yet", 32'(overflow), 32'd0);
      chk("ovf_full_count", 32'(fifo_count), 32'd4);
      wb(5'd7, 32'hA000_0007);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_count_kept", 32'(fifo_count), 32'd4);
      ovf_clr = 1'b1;
      wb(5'd8, 32'hA000_0008);
      ovf_clr = 1'b0;
      chk("ovf_set_priority", 32'(overflow), 32'd1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("ovf_cleared", 32'(overflow), 32'd0);
      wait_idle(100);
      chk("ovf_final", cur_disp(), 32'hA000_0006);

      // Zero value, then reset mid-HOLD with two events queued
      exp_q.push_back(mk(32'h0000_0000, 8'hFE, 0));
      wb(5'd3, 32'h0);
      wb(5'd4, 32'h0000_000A);
      wb(5'd6, 32'h0000_000B);
      chk("zero_queued", 32'(fifo_count), 32'd2);
      exp_q.push_back(mk(32'hFFFF_FFFF, 8'hFF, 0));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_digits", cur_disp(), 32'hFFFF_FFFF);
      chk("mid_rst_blank", 32'(digit_blank), 32'h0000_00FF);
      chk("mid_rst_count", 32'(fifo_count), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      repeat (20) tick();
      chk("mid_rst_dark", cur_disp(), 32'hFFFF_FFFF);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
